// File: rtl/yarvi_mem_arbiter.sv
// yarvi_mem_arbiter: round-robin sharing of one single-port, word-wide RAM between
// instruction fetch (port 0) and load/store (port 1), with a fixed one-cycle response.
module yarvi_mem_arbiter #(
    parameter int MEMWORDS_LG2 = 16,
    parameter int ADDR_CHK_HI  = 28
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [31:0]             req0_addr,
    input  logic                    req0_wr,
    input  logic [31:0]             req0_wdata,
    input  logic [3:0]              req0_wmask,

    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [31:0]             req1_addr,
    input  logic                    req1_wr,
    input  logic [31:0]             req1_wdata,
    input  logic [3:0]              req1_wmask,

    output logic                    resp0_valid,
    output logic [31:0]             resp0_rdata,
    output logic                    resp0_err,
    output logic                    resp1_valid,
    output logic [31:0]             resp1_rdata,
    output logic                    resp1_err,

    output logic [MEMWORDS_LG2-1:0] mem_addr,
    output logic                    mem_en,
    output logic [3:0]              mem_we,
    output logic [31:0]             mem_wdata,
    input  logic [31:0]             mem_rdata
);

    logic        r_last_grant;
    logic        r_tag_valid;
    logic        r_tag_port;
    logic        r_tag_wr;
    logic        r_tag_err;

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_accept;
    logic        w_port;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [3:0]  w_wmask;
    logic        w_wr;
    logic        w_oor;
    logic [31:0] w_rdata;

    // On contention the port that did not win last time goes first; with reset low nothing is granted.
    assign w_gnt0   = reset && req0_valid && (!req1_valid || r_last_grant);
    assign w_gnt1   = reset && req1_valid && (!req0_valid || !r_last_grant);
    assign w_accept = w_gnt0 || w_gnt1;
    assign w_port   = w_gnt1;

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    assign w_addr  = w_port ? req1_addr  : req0_addr;
    assign w_wdata = w_port ? req1_wdata : req0_wdata;
    assign w_wmask = w_port ? req1_wmask : req0_wmask;
    assign w_wr    = w_port ? req1_wr    : req0_wr;
    assign w_oor   = |w_addr[ADDR_CHK_HI:MEMWORDS_LG2+2];

    assign mem_addr  = w_addr[MEMWORDS_LG2+1:2];
    assign mem_wdata = w_wdata;
    assign mem_en    = w_accept && !w_oor;
    assign mem_we    = (mem_en && w_wr) ? w_wmask : 4'h0;

    logic w_unused;
    if (ADDR_CHK_HI < 31) begin : g_unused_hi
        assign w_unused = ^{w_addr[31:ADDR_CHK_HI+1], w_addr[1:0]};
    end else begin : g_unused_lo
        assign w_unused = ^w_addr[1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last_grant <= 1'b1;
            r_tag_valid  <= 1'b0;
            r_tag_port   <= 1'b0;
            r_tag_wr     <= 1'b0;
            r_tag_err    <= 1'b0;
        end else begin
            r_tag_valid <= w_accept;
            if (w_accept) begin
                r_last_grant <= w_port;
                r_tag_port   <= w_port;
                r_tag_wr     <= w_wr;
                r_tag_err    <= w_oor;
            end
        end
    end

    // RAM data is only meaningful for an in-range read issued on the previous cycle.
    assign w_rdata = (r_tag_valid && !r_tag_wr && !r_tag_err) ? mem_rdata : 32'h0;

    assign resp0_valid = r_tag_valid && !r_tag_port;
    assign resp1_valid = r_tag_valid &&  r_tag_port;
    assign resp0_rdata = resp0_valid ? w_rdata : 32'h0;
    assign resp1_rdata = resp1_valid ? w_rdata : 32'h0;
    assign resp0_err   = resp0_valid && r_tag_err;
    assign resp1_err   = resp1_valid && r_tag_err;

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (reset && w_accept && w_oor)
            $display("yarvi_mem_arbiter: out-of-range access addr=0x%08h port=%0d", w_addr, w_port);
    end
`endif

endmodule

// File: tb/tb_yarvi_mem_arbiter.sv
// Scoreboard bench for yarvi_mem_arbiter: directed scenarios then random traffic,
// checked against a word-array reference memory and a simple who-goes-next rule.
module tb_yarvi_mem_arbiter;

    localparam int LG2    = 16;
    localparam int CHK_HI = 28;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              req0_valid = 1'b0, req1_valid = 1'b0;
    logic              req0_ready, req1_ready;
    logic [31:0]       req0_addr = '0, req1_addr = '0;
    logic              req0_wr = 1'b0, req1_wr = 1'b0;
    logic [31:0]       req0_wdata = '0, req1_wdata = '0;
    logic [3:0]        req0_wmask = '0, req1_wmask = '0;
    logic              resp0_valid, resp1_valid;
    logic [31:0]       resp0_rdata, resp1_rdata;
    logic              resp0_err, resp1_err;
    logic [LG2-1:0]    mem_addr;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    always #5 clock = ~clock;

    yarvi_mem_arbiter #(.MEMWORDS_LG2(LG2), .ADDR_CHK_HI(CHK_HI)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_wr(req0_wr), .req0_wdata(req0_wdata), .req0_wmask(req0_wmask),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_wr(req1_wr), .req1_wdata(req1_wdata), .req1_wmask(req1_wmask),
        .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
        .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous read-first RAM attached to the arbiter.
    logic [31:0] ram [0:(1<<LG2)-1];
    logic [31:0] ram_q = '0;
    always @(posedge clock) begin
        if (mem_en) begin
            ram_q <= ram[mem_addr];
            for (int i = 0; i < 4; i++)
                if (mem_we[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
    end
    assign mem_rdata = ram_q;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic [31:0] ref_mem [int];
    exp_t        expq[$];
    int          prefer;
    int          last_g;
    int          cyc;
    int          wait0, wait1;
    int          n_checks, n_errors;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=0x%08h want=0x%08h cycle=%0d", name, got, want, cyc);
        end
    endtask

    // Reference: sample the requests, decide who should be served, predict RAM strobes and the response.
    task automatic model_check();
        int          g;
        logic [31:0] a, d, old, nw;
        logic [3:0]  m;
        logic        w, oor;
        int          word;
        exp_t        e;
        g = -1;
        if (reset) begin
            if (req0_valid && req1_valid) g = prefer;
            else if (req0_valid)          g = 0;
            else if (req1_valid)          g = 1;
        end
        last_g = g;
        chk("req0_ready", {31'b0, req0_ready}, {31'b0, g == 0});
        chk("req1_ready", {31'b0, req1_ready}, {31'b0, g == 1});
        if (reset) begin
            wait0 = (req0_valid && !req0_ready) ? wait0 + 1 : 0;
            wait1 = (req1_valid && !req1_ready) ? wait1 + 1 : 0;
            chk("fair_wait0", {31'b0, wait0 <= 1}, 32'd1);
            chk("fair_wait1", {31'b0, wait1 <= 1}, 32'd1);
        end
        if (g < 0) begin
            chk("idle_mem_en", {31'b0, mem_en}, 32'd0);
            chk("idle_mem_we", {28'b0, mem_we}, 32'd0);
            return;
        end
        if (g == 0) begin a = req0_addr; w = req0_wr; d = req0_wdata; m = req0_wmask; end
        else        begin a = req1_addr; w = req1_wr; d = req1_wdata; m = req1_wmask; end
        oor  = (a[CHK_HI:LG2+2] != 0);
        word = int'(a[LG2+1:2]);
        chk("mem_en", {31'b0, mem_en}, {31'b0, !oor});
        chk("mem_we", {28'b0, mem_we}, (w && !oor) ? {28'b0, m} : 32'd0);
        if (!oor) chk("mem_addr", {16'b0, mem_addr}, word);
        if (!oor && w && m != 0) chk("mem_wdata", mem_wdata, d);
        old = ref_mem.exists(word) ? ref_mem[word] : 32'h0;
        if (w && !oor) begin
            nw = old;
            for (int i = 0; i < 4; i++)
                if (m[i]) nw[8*i +: 8] = d[8*i +: 8];
            ref_mem[word] = nw;
        end
        e.port  = g;
        e.rdata = (!w && !oor) ? old : 32'h0;
        e.err   = oor;
        e.cyc   = cyc;
        expq.push_back(e);
        prefer = 1 - g;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clock) begin
        exp_t e;
        int   p;
        if (resp0_valid && resp1_valid) chk("resp_both_ports", 32'd1, 32'd0);
        if (resp0_valid || resp1_valid) begin
            p = resp1_valid ? 1 : 0;
            if (expq.size() == 0) begin
                chk("resp_unexpected", {31'b0, resp1_valid}, 32'hFFFF_FFFF);
            end else begin
                e = expq.pop_front();
                chk("resp_latency", cyc - e.cyc, 32'd1);
                chk("resp_port", p, e.port);
                chk("resp_rdata", p ? resp1_rdata : resp0_rdata, e.rdata);
                chk("resp_err", {31'b0, p ? resp1_err : resp0_err}, {31'b0, e.err});
                chk("resp_other_idle", p ? {31'b0, resp0_err} | resp0_rdata
                                         : {31'b0, resp1_err} | resp1_rdata, 32'd0);
            end
        end else begin
            chk("resp_idle", {31'b0, resp0_err | resp1_err} | resp0_rdata | resp1_rdata, 32'd0);
            if (expq.size() > 0 && expq[0].cyc < cyc) begin
                e = expq.pop_front();
                chk("resp_missing", 32'd0, 32'd1);
            end
        end
    end

    task automatic set_req(input int p, input logic v, input logic [31:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] m);
        if (p == 0) begin
            req0_valid = v; req0_addr = a; req0_wr = w; req0_wdata = d; req0_wmask = m;
        end else begin
            req1_valid = v; req1_addr = a; req1_wr = w; req1_wdata = d; req1_wmask = m;
        end
    endtask

    task automatic step();
        @(negedge clock);
        model_check();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_model();
        prefer = 0;
        wait0  = 0;
        wait1  = 0;
        expq.delete();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int          r;
        a = ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
        r = $urandom_range(0, 19);
        if (r == 0) a = a | (32'h1 << $urandom_range(LG2 + 2, CHK_HI));
        if (r == 1) a = a | (32'h1 << $urandom_range(CHK_HI + 1, 31));
        return a;
    endfunction

    initial begin
        for (int i = 0; i < (1 << LG2); i++) ram[i] = 32'h0;
        ram[5] = 32'h1234_5678;
        ref_mem[5] = 32'h1234_5678;
        reset_model();

        // Reset: outputs quiet and no grant even with both ports requesting.
        #2;
        chk("rst_resp0_valid", {31'b0, resp0_valid}, 32'd0);
        chk("rst_resp1_valid", {31'b0, resp1_valid}, 32'd0);
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        set_req(0, 1'b1, 32'h0, 1'b0, 32'h0, 4'h0);
        set_req(1, 1'b1, 32'h4, 1'b0, 32'h0, 4'h0);
        step();
        step();
        set_req(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        set_req(1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        reset = 1'b1;
        step();

        // Single read on port 1.
        set_req(1, 1'b1, 32'h14, 1'b0, 32'h0, 4'h0);
        step();
        set_req(1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        step();

        // Contention: both ports request every cycle.
        set_req(0, 1'b1, 32'h14, 1'b0, 32'h0, 4'h0);
        set_req(1, 1'b1, 32'h18, 1'b0, 32'h0, 4'h0);
        repeat (6) step();
        set_req(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        set_req(1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        step();

        // Byte lanes followed by a read-after-write of the same word.
        set_req(0, 1'b1, 32'h100, 1'b1, 32'hAABB_CCDD, 4'hF); step();
        set_req(0, 1'b1, 32'h100, 1'b1, 32'h00EE_0000, 4'h4); step();
        set_req(0, 1'b1, 32'h100, 1'b0, 32'h0, 4'h0);         step();
        set_req(0, 1'b1, 32'h104, 1'b1, 32'h5555_5555, 4'h0); step();
        set_req(0, 1'b1, 32'h104, 1'b0, 32'h0, 4'h0);         step();

        // Out of range: read, write that must not land in RAM, then read back word 0.
        set_req(0, 1'b1, 32'h0004_0000, 1'b0, 32'h0, 4'h0);         step();
        set_req(0, 1'b1, 32'h0010_0000, 1'b1, 32'hDEAD_BEEF, 4'hF); step();
        set_req(0, 1'b1, 32'h0000_0000, 1'b0, 32'h0, 4'h0);         step();
        set_req(0, 1'b1, 32'h1FFF_FFFC, 1'b0, 32'h0, 4'h0);         step();
        set_req(0, 1'b1, 32'hE000_0014, 1'b0, 32'h0, 4'h0);         step();
        set_req(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);

        // Withdrawal: port 0 has priority, port 1 drops its write before being served.
        set_req(1, 1'b1, 32'h20, 1'b0, 32'h0, 4'h0); step();
        set_req(0, 1'b1, 32'h24, 1'b0, 32'h0, 4'h0);
        set_req(1, 1'b1, 32'h1C, 1'b1, 32'hCAFE_F00D, 4'hF); step();
        set_req(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        set_req(1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0); step();
        chk("withdraw_ram_word7", ram[7], 32'h0);

        // Stall: port 0 is held while port 1 wins, then served next cycle.
        set_req(0, 1'b1, 32'h28, 1'b1, 32'h0102_0304, 4'h3);
        set_req(1, 1'b1, 32'h2C, 1'b0, 32'h0, 4'h0); step();
        set_req(1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);  step();
        set_req(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);  step();

        // Reset mid-flight: the pending response must vanish at once.
        set_req(0, 1'b1, 32'h14, 1'b0, 32'h0, 4'h0); step();
        set_req(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        chk("inflight_resp0_valid", {31'b0, resp0_valid}, 32'd1);
        #2;
        reset = 1'b0;
        reset_model();
        #1;
        chk("midrst_resp0_valid", {31'b0, resp0_valid}, 32'd0);
        chk("midrst_resp1_valid", {31'b0, resp1_valid}, 32'd0);
        set_req(0, 1'b1, 32'h30, 1'b0, 32'h0, 4'h0);
        set_req(1, 1'b1, 32'h34, 1'b0, 32'h0, 4'h0);
        step();
        reset = 1'b1;
        reset_model();
        step();
        chk("post_reset_first_grant", {31'b0, last_g == 0}, 32'd1);
        set_req(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        step();
        set_req(1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        step();

        // Random traffic with hold-while-waiting and occasional withdrawal.
        for (int i = 0; i < 2000; i++) begin
            for (int p = 0; p < 2; p++) begin
                logic v;
                v = (p == 0) ? req0_valid : req1_valid;
                if (v && last_g != p) begin
                    if ($urandom_range(0, 15) == 0) begin
                        if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
                    end
                end else begin
                    set_req(p, $urandom_range(0, 3) != 0, rand_addr(), 1'($urandom_range(0, 1)),
                            $urandom(), 4'($urandom_range(0, 15)));
                end
            end
            step();
        end

        set_req(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        set_req(1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        repeat (3) step();
        chk("scoreboard_drained", expq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/yarvi_mem_arbiter.md
Name: yarvi_mem_arbiter

Overview:
- Shares the single-port, word-wide data memory between two requesters: port 0 is instruction fetch, port 1 is load/store. A second core may be attached to either port instead.
- Round-robin arbitration, valid/ready request handshake, fixed one-cycle response, per-byte write lanes and an out-of-range check.
- Sits between the yarvi core(s) and the synchronous RAM array.

Parameters:
- MEMWORDS_LG2, 16, log2 of memory size in 32-bit words.
- ADDR_CHK_HI, 28, highest byte-address bit checked; addr[ADDR_CHK_HI:MEMWORDS_LG2+2] must be zero.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  request present on port n.
- req0_ready / req1_ready  out  1  request on port n accepted this cycle.
- req0_addr / req1_addr  in  32  byte address; bits [1:0] ignored.
- req0_wr / req1_wr  in  1  1 = write, 0 = read.
- req0_wdata / req1_wdata  in  32  write data, already lane-aligned.
- req0_wmask / req1_wmask  in  4  byte-lane enables; bit i covers wdata[8i+7:8i].
- resp0_valid / resp1_valid  out  1  one-cycle pulse, response for port n.
- resp0_rdata / resp1_rdata  out  32  read data; 0 for writes and errors.
- resp0_err / resp1_err  out  1  out-of-range access, qualified by respN_valid.
- mem_addr  out  MEMWORDS_LG2  RAM word index = addr[MEMWORDS_LG2+1:2].
- mem_en  out  1  RAM access strobe.
- mem_we  out  4  RAM byte write enables.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, valid one cycle after mem_en with mem_we == 0.

Behaviour:
- Reset (reset low, async):
  - respN_valid = 0, respN_err = 0, respN_rdata = 0.
  - reqN_ready = 0 while reset is low.
  - mem_en = 0, mem_we = 0.
  - last_grant = 1, so port 0 wins the first contention.
  - Any in-flight response is dropped.
- Arbitration (combinational on reqN_valid and last_grant):
  - Only one valid: that port is granted.
  - Both valid: the port != last_grant is granted.
  - reqN_ready = grant to N. At most one ready per cycle. No bubble cycles: sustained throughput is one request per clock.
- Accept cycle (valid && ready):
  - Drive mem_addr, mem_wdata, mem_en.
  - Range check: out of range if addr[ADDR_CHK_HI:MEMWORDS_LG2+2] != 0. An out-of-range request still completes the handshake but forces mem_en = 0 and mem_we = 0.
  - mem_we = wr ? wmask : 0.
  - A write with wmask == 0 is legal: it performs no RAM update and returns a normal response.
  - last_grant updates to the granted port at the clock edge. It is unchanged in cycles with no grant.
- Response pipeline: the registered tag {port, wr, err, valid} is captured at the accept edge. The next cycle:
  - respN_valid = 1 for exactly that cycle on the tagged port.
  - respN_rdata = mem_rdata for an in-range read, else 0.
  - respN_err = err.
  - The other port's resp outputs are 0.
- There is no response backpressure: requesters must sink responses. Latency from accept edge to response is exactly 1 cycle.
- Requester rule: req fields must be held stable while reqN_valid = 1 and reqN_ready = 0. A deasserted valid before grant is a legal withdrawal.
- Read-after-write: the RAM is read-first within a cycle, but accesses are serialized. A read accepted the cycle after a write to the same word returns the written data with lanes merged.
- Fairness: a continuously requesting port waits at most 1 cycle.
- Reset mid-operation: on assertion, a response due next cycle is not issued. After deassertion the arbiter starts with the port-0 preference.
- Error display: in simulation only, an out-of-range access prints the address and port. It does not stop simulation; the core decides.

Test Plan:
- Single read: after reset, mem[5] = 0x12345678, req1 read addr 0x14 -> req1_ready = 1 same cycle; next cycle resp1_valid = 1, resp1_rdata = 0x12345678, resp1_err = 0, resp0_valid = 0.
- Contention: both ports request every cycle for 6 cycles -> grants alternate 0,1,0,1,0,1; each response arrives the cycle after its grant on the correct port.
- Byte lanes: write 0xAABBCCDD mask 0xF to 0x100, then write 0x00EE0000 mask 0x4, then read 0x100 -> 0xAAEECCDD, returned on the cycle after the read is accepted.
- Out of range: read addr 0x0004_0000 (bit 18 set, MEMWORDS_LG2 = 16) -> mem_en = 0, response next cycle with err = 1 and rdata = 0. A write to 0x0010_0000 leaves RAM unchanged and returns err = 1.
- Withdrawal and stall: port 1 valid while port 0 holds grant priority; port 1 drops valid before grant -> no port-1 response, no RAM access. A held request keeps its fields stable and is granted within 1 cycle.
- Reset mid-flight: assert reset low mid-cycle after a read is accepted -> resp0_valid and resp1_valid stay 0 immediately (async). After release, a simultaneous request from both ports grants port 0 first.
